// File: rtl/bcd_pkg.sv
// Shared types and elaboration-time helpers for the BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int BCD_MAX = 9;

    // Bits needed to hold 10^n - 1.
    function automatic int pow10_clog2(input int n);
        longint unsigned p;
        int              b;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        b = 0;
        while ((64'(1) << b) < p) begin
            b++;
        end
        return b;
    endfunction

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One BCD digit step: next_acc = acc*10 + digit, with invalid nibbles contributing zero.
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0] acc,
    input  logic [3:0]       nibble,
    output logic [BIN_W-1:0] next_acc,
    output logic             invalid
);

    logic [3:0] digit;

    always_comb begin
        invalid  = (nibble > 4'(BCD_MAX));
        digit    = invalid ? 4'd0 : nibble;
        next_acc = (acc << 3) + (acc << 1) + BIN_W'(digit);
    end

endmodule

// File: rtl/bcd_to_binary_conv.sv
// Iterative multi-digit BCD-to-binary converter, one digit per clock, MSD first.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for in_valid; in_ready high
//   CONV  | folding one digit per cycle into acc; cnt counts down
//   DONE  | result held on out_* with out_valid high until out_ready
module bcd_to_binary_conv
    import bcd_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int BIN_W  = pow10_clog2(DIGITS),
    localparam int POS_W  = safe_clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_bin,
    output logic                  out_err,
    output logic [POS_W-1:0]      out_err_pos
);

    state_t              state, state_nxt;
    logic [4*DIGITS-1:0] shreg;
    logic [BIN_W-1:0]    acc, mac_acc;
    logic [POS_W-1:0]    cnt, err_pos, pos_nxt;
    logic                err, err_nxt, mac_inv, last_digit;

    bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
        .acc      (acc),
        .nibble   (shreg[4*DIGITS-1 -: 4]),
        .next_acc (mac_acc),
        .invalid  (mac_inv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = CONV;
            CONV:    if (last_digit) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);

    // cnt is the index of the digit being consumed, so it doubles as the error position.
    assign last_digit = (cnt == '0);
    assign err_nxt    = err | mac_inv;
    assign pos_nxt    = (mac_inv && !err) ? cnt : err_pos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg       <= '0;
            acc         <= '0;
            cnt         <= '0;
            err         <= 1'b0;
            err_pos     <= '0;
            out_bin     <= '0;
            out_err     <= 1'b0;
            out_err_pos <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg   <= in_bcd;
                        acc     <= '0;
                        cnt     <= POS_W'(DIGITS - 1);
                        err     <= 1'b0;
                        err_pos <= '0;
                    end
                end
                CONV: begin
                    shreg   <= shreg << 4;
                    acc     <= mac_acc;
                    err     <= err_nxt;
                    err_pos <= pos_nxt;
                    if (last_digit) begin
                        out_bin     <= mac_acc;
                        out_err     <= err_nxt;
                        out_err_pos <= pos_nxt;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_conv.sv
// Directed bench for bcd_to_binary_conv at DIGITS=4, plus DIGITS=1 and DIGITS=9 instances.
module tb_bcd_to_binary_conv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] in_bcd = '0;
    logic        in_ready, out_valid, out_err;
    logic [13:0] out_bin;
    logic [1:0]  out_err_pos;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic [3:0]  in_bcd1 = '0;
    logic        in_ready1, out_valid1, out_err1;
    logic [3:0]  out_bin1;
    logic [0:0]  out_err_pos1;

    logic        in_valid9 = 1'b0, out_ready9 = 1'b1;
    logic [35:0] in_bcd9 = '0;
    logic        in_ready9, out_valid9, out_err9;
    logic [29:0] out_bin9;
    logic [3:0]  out_err_pos9;

    bcd_to_binary_conv #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .out_err(out_err), .out_err_pos(out_err_pos)
    );

    bcd_to_binary_conv #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_bcd(in_bcd1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_bin(out_bin1),
        .out_err(out_err1), .out_err_pos(out_err_pos1)
    );

    bcd_to_binary_conv #(.DIGITS(9)) dut9 (
        .clk(clk), .rst(rst), .in_valid(in_valid9), .in_ready(in_ready9), .in_bcd(in_bcd9),
        .out_valid(out_valid9), .out_ready(out_ready9), .out_bin(out_bin9),
        .out_err(out_err9), .out_err_pos(out_err_pos9)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one word on the DIGITS=4 instance with out_ready high; starts and ends in IDLE.
    task automatic convert(input string tag, input logic [15:0] bcd,
                           input int exp_bin, input logic exp_err, input int exp_pos);
        int lat;
        in_bcd    = bcd;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        chk({tag, "_busy"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd4);
        chk({tag, "_bin"}, 64'(out_bin), 64'(exp_bin));
        chk({tag, "_err"}, 64'(out_err), 64'(exp_err));
        chk({tag, "_pos"}, 64'(out_err_pos), 64'(exp_pos));
        tick();
        chk({tag, "_vdrop"}, 64'(out_valid), 64'd0);
        chk({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int seen;

        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_bin", 64'(out_bin), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        convert("nom1234", 16'h1234, 1234, 1'b0, 0);
        convert("zero", 16'h0000, 0, 1'b0, 0);
        convert("max9999", 16'h9999, 9999, 1'b0, 0);
        convert("inv12A4", 16'h12A4, 1204, 1'b1, 1);
        convert("invF0B0", 16'hF0B0, 0, 1'b1, 3);
        convert("inv123F", 16'h123F, 1230, 1'b1, 0);

        // Backpressure with an ignored in_valid pulse carrying 5555.
        in_bcd    = 16'h0987;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_lat", 64'(lat), 64'd4);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_bcd   = 16'h5555;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_bin", 64'(out_bin), 64'd987);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        chk("bp_hold_bin", 64'(out_bin), 64'd987);
        tick();
        chk("bp_no_queue", 64'(in_ready), 64'd1);
        convert("after_bp", 16'h0010, 10, 1'b0, 0);

        // Reset two cycles into converting 4321.
        in_bcd   = 16'h4321;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_bin", 64'(out_bin), 64'd0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("aborted_no_valid", 64'(seen), 64'd0);
        convert("post_rst42", 16'h0042, 42, 1'b0, 0);

        // DIGITS=1
        in_bcd1   = 4'h7;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("d1_lat", 64'(lat), 64'd1);
        chk("d1_bin", 64'(out_bin1), 64'd7);
        chk("d1_err", 64'(out_err1), 64'd0);
        tick();

        // DIGITS=9 maximum value
        in_bcd9   = 36'h999999999;
        in_valid9 = 1'b1;
        tick();
        in_valid9 = 1'b0;
        lat = 0;
        while (!out_valid9 && lat < 40) begin
            tick();
            lat++;
        end
        chk("d9_lat", 64'(lat), 64'd9);
        chk("d9_bin", 64'(out_bin9), 64'd999999999);
        chk("d9_err", 64'(out_err9), 64'd0);
        tick();

        // DIGITS=9 with the most significant digit invalid
        in_bcd9   = 36'hF00000001;
        in_valid9 = 1'b1;
        tick();
        in_valid9 = 1'b0;
        lat = 0;
        while (!out_valid9 && lat < 40) begin
            tick();
            lat++;
        end
        chk("d9inv_lat", 64'(lat), 64'd9);
        chk("d9inv_bin", 64'(out_bin9), 64'd1);
        chk("d9inv_err", 64'(out_err9), 64'd1);
        chk("d9inv_pos", 64'(out_err_pos9), 64'd8);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
